max_job_issuer: RTL and testbench
=================================

MAX_JOB_ISSUER -- requirements
Module: max_job_issuer

Interface
REQ-001 Parameter WIDTH, default 5, operand width in bits.
REQ-002 Parameter TIMEOUT, default 64, maximum number of cycles spent waiting for done before an abort.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  an upstream operand is present.
REQ-006 in_data  input  WIDTH  upstream operand.
REQ-007 in_ready  output  1  block accepts an operand this cycle.
REQ-008 start_signal  output  1  start request to the maximum-finder.
REQ-009 X1, X2, X3, X4  output  WIDTH each  operands presented to the maximum-finder.
REQ-010 done  input  1  completion indication from the maximum-finder.
REQ-011 maximum_number  input  5  result from the maximum-finder.
REQ-012 res_valid  output  1  a result or an abort is available downstream.
REQ-013 res_data  output  5  captured maximum; 0 on abort.
REQ-014 res_error  output  1  qualifies res_valid: set means timeout abort.
REQ-015 res_ready  input  1  downstream accepts the result.
REQ-016 busy  output  1  high in every state except COLLECT with count 0.

Function
REQ-017 The FSM SHALL have exactly four states: COLLECT, START, WAIT, DELIVER.
REQ-018 COLLECT: in_ready=1; each in_valid&in_ready cycle loads in_data into X[count+1]; the 2-bit count increments.
REQ-019 The 4th accepted operand (count=3) SHALL move the FSM to START on the next edge, with count wrapping to 0.
REQ-020 START SHALL last exactly one cycle with start_signal=1, then move to WAIT; start_signal SHALL be 0 in every other state.
REQ-021 X1..X4 SHALL remain stable from leaving COLLECT until DELIVER is exited.
REQ-022 WAIT: a 16-bit watchdog SHALL count up from 0; done=1 captures maximum_number into res_data, clears res_error, and moves to DELIVER.
REQ-023 WAIT without done, watchdog = TIMEOUT-1: res_data=0, res_error=1, move to DELIVER.
REQ-024 If done and the timeout coincide in the same cycle, done SHALL win.
REQ-025 done SHALL be ignored in COLLECT, START, and DELIVER.
REQ-026 DELIVER: res_valid=1; res_data and res_error SHALL be held until res_valid&res_ready, then the FSM returns to COLLECT.
REQ-027 in_ready SHALL be 0 outside COLLECT; no operand is lost or overwritten.
REQ-028 Latency: the 4th operand accept to start_signal is 1 cycle; done to res_valid is 1 cycle.

Reset
REQ-029 rst=1 SHALL immediately force: state COLLECT, count 0, watchdog 0, X1..X4 = 0, res_data 0, res_error 0.
REQ-030 During and after reset, outputs SHALL be: start_signal 0, res_valid 0, in_ready 1 (after release), busy 0.
REQ-031 Reset mid-operation, in any state, SHALL discard partial operands and any pending result.

Structure
REQ-032 A shared package SHALL hold the state encoding (2 bits), the default WIDTH/TIMEOUT constants, and the result width (5).
REQ-033 The block SHALL be split into controller and datapath; one sub-module, max_job_issuer_controller, holds the FSM and watchdog.
REQ-034 The datapath (operand registers, count, result register) SHALL stay in max_job_issuer.

Verification
REQ-035 Scenario: stream 3,17,9,30 with in_valid constant high -> X1..X4=3,17,9,30; start_signal high for exactly 1 cycle after the 4th accept.
REQ-036 Scenario: responder returns done with maximum_number=30 after 5 cycles, res_ready=1 -> res_valid for 1 cycle, res_data=30, res_error=0; FSM back in COLLECT.
REQ-037 Scenario: done never asserted, TIMEOUT=8 -> res_valid exactly 8 cycles after START; res_data=0, res_error=1.
REQ-038 Scenario: res_ready held low for 10 cycles -> res_valid and res_data stable throughout; in_ready=0; new in_valid pulses not accepted.
REQ-039 Scenario: rst asserted after 2 operands (1,2) -> all outputs reset asynchronously; next 4 operands 5,6,7,8 land in X1..X4 in order.
REQ-040 Scenario: done and the timeout in the same cycle -> res_error=0, res_data=maximum_number.

Source files
------------

// File: rtl/max_job_issuer_pkg.sv
// Shared types and constants for the maximum-finder job issuer.
// Holds the FSM encoding plus default sizing used by the top and controller.
package max_job_issuer_pkg;

  localparam int DEF_WIDTH   = 5;
  localparam int DEF_TIMEOUT = 64;
  localparam int RES_W       = 5;
  localparam int WD_W        = 16;
  localparam int N_OPS       = 4;

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_START   = 2'd1,
    S_WAIT    = 2'd2,
    S_DELIVER = 2'd3
  } state_t;

endpackage

// File: rtl/max_job_issuer_controller.sv
// Job sequencing FSM with the done watchdog.
// Issues capture strobes to the datapath and owns all handshake outputs.
module max_job_issuer_controller
  import max_job_issuer_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic last_accept,
  input  logic done,
  input  logic res_ready,
  output logic in_ready,
  output logic start_signal,
  output logic res_valid,
  output logic cap_ok,
  output logic cap_to
);

  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_t          state;
  logic [WD_W-1:0] wd;
  logic            in_wait;

  assign in_wait = (state == S_WAIT);
  // done takes priority over an expiring watchdog
  assign cap_ok  = in_wait & done;
  assign cap_to  = in_wait & ~done & (wd == WD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_COLLECT;
      wd           <= '0;
      in_ready     <= 1'b1;
      start_signal <= 1'b0;
      res_valid    <= 1'b0;
    end else begin
      unique case (state)
        S_COLLECT: begin
          if (last_accept) begin
            state        <= S_START;
            in_ready     <= 1'b0;
            start_signal <= 1'b1;
          end
        end
        S_START: begin
          state        <= S_WAIT;
          start_signal <= 1'b0;
          wd           <= '0;
        end
        S_WAIT: begin
          if (cap_ok || cap_to) begin
            state     <= S_DELIVER;
            res_valid <= 1'b1;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        S_DELIVER: begin
          if (res_ready) begin
            state     <= S_COLLECT;
            res_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= S_COLLECT;
      endcase
    end
  end

endmodule

// File: rtl/max_job_issuer.sv
// Collects four operands, launches the maximum-finder and returns its result.
// Operand, count and result registers live here; sequencing is in the controller.
module max_job_issuer
  import max_job_issuer_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             start_signal,
  output logic [WIDTH-1:0] X1,
  output logic [WIDTH-1:0] X2,
  output logic [WIDTH-1:0] X3,
  output logic [WIDTH-1:0] X4,
  input  logic             done,
  input  logic [RES_W-1:0] maximum_number,
  output logic             res_valid,
  output logic [RES_W-1:0] res_data,
  output logic             res_error,
  input  logic             res_ready,
  output logic             busy
);

  logic [1:0]       count;
  logic [WIDTH-1:0] x_q [N_OPS];
  logic             accept;
  logic             last_accept;
  logic             cap_ok;
  logic             cap_to;

  assign accept      = in_valid & in_ready;
  assign last_accept = accept & (count == 2'd3);
  assign busy        = ~(in_ready & (count == 2'd0));

  assign X1 = x_q[0];
  assign X2 = x_q[1];
  assign X3 = x_q[2];
  assign X4 = x_q[3];

  max_job_issuer_controller #(
    .TIMEOUT (TIMEOUT)
  ) u_ctrl (
    .clk          (clk),
    .rst          (rst),
    .last_accept  (last_accept),
    .done         (done),
    .res_ready    (res_ready),
    .in_ready     (in_ready),
    .start_signal (start_signal),
    .res_valid    (res_valid),
    .cap_ok       (cap_ok),
    .cap_to       (cap_to)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      x_q       <= '{default: '0};
      res_data  <= '0;
      res_error <= 1'b0;
    end else begin
      // operands only load while collecting, so X stays frozen during a job
      if (accept) begin
        x_q[count] <= in_data;
        count      <= count + 2'd1;
      end
      if (cap_ok) begin
        res_data  <= maximum_number;
        res_error <= 1'b0;
      end else if (cap_to) begin
        res_data  <= '0;
        res_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_max_job_issuer.sv
// Scenario bench for max_job_issuer with a result scoreboard.
// Runs with TIMEOUT=8 so the watchdog path is short.
module tb_max_job_issuer;

  localparam int W  = 5;
  localparam int TO = 8;

  typedef struct packed {
    logic [4:0] data;
    logic       err;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready;
  logic         start_signal;
  logic [W-1:0] X1, X2, X3, X4;
  logic         done = 1'b0;
  logic [4:0]   maximum_number = '0;
  logic         res_valid;
  logic [4:0]   res_data;
  logic         res_error;
  logic         res_ready = 1'b1;
  logic         busy;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  max_job_issuer #(
    .WIDTH   (W),
    .TIMEOUT (TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .start_signal   (start_signal),
    .X1             (X1),
    .X2             (X2),
    .X3             (X3),
    .X4             (X4),
    .done           (done),
    .maximum_number (maximum_number),
    .res_valid      (res_valid),
    .res_data       (res_data),
    .res_error      (res_error),
    .res_ready      (res_ready),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "global timeout");
  end

  function automatic logic [4:0] max4(input logic [4:0] a, b, c, d);
    logic [4:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Feeds four operands back-to-back; returns at the negedge in START.
  task automatic stream(input logic [4:0] a, b, c, d);
    logic [4:0] ops [4];
    ops = '{a, b, c, d};
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = ops[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
    checks++;
    if (start_signal !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl got start=%b valid=%b busy=%b exp=0,0,0",
               start_signal, res_valid, busy);
    end
    checks++;
    if ({X1, X2, X3, X4} !== 20'd0) begin
      failures++;
      $display("FAIL reset_x got=%h exp=0", {X1, X2, X3, X4});
    end
    checks++;
    if (res_data !== 5'd0 || res_error !== 1'b0) begin
      failures++;
      $display("FAIL reset_res got=%0d/%b exp=0/0", res_data, res_error);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got ready=%b busy=%b exp=1,0", in_ready, busy);
    end
  endtask

  // done is held high throughout collection and START to show it is ignored.
  task automatic test_stream;
    res_ready      = 1'b1;
    done           = 1'b1;
    maximum_number = 5'd31;
    stream(5'd3, 5'd17, 5'd9, 5'd30);
    checks++;
    if ({X1, X2, X3, X4} !== {5'd3, 5'd17, 5'd9, 5'd30}) begin
      failures++;
      $display("FAIL stream_x got=%0d,%0d,%0d,%0d exp=3,17,9,30", X1, X2, X3, X4);
    end
    checks++;
    if (start_signal !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL stream_start got start=%b ready=%b busy=%b exp=1,0,1",
               start_signal, in_ready, busy);
    end
    @(negedge clk);
    checks++;
    if (start_signal !== 1'b0 || res_valid !== 1'b0) begin
      failures++;
      $display("FAIL stream_start_width got start=%b valid=%b exp=0,0",
               start_signal, res_valid);
    end
    done = 1'b0;
  endtask

  task automatic test_done;
    int   n;
    exp_t e;
    repeat (3) @(negedge clk);
    done           = 1'b1;
    maximum_number = max4(5'd3, 5'd17, 5'd9, 5'd30);
    sb.push_back('{data: maximum_number, err: 1'b0});
    @(negedge clk);
    done = 1'b0;
    n = 0;
    while (!res_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 0) begin
      failures++;
      $display("FAIL done_latency got=%0d exp=0 extra cycles", n);
    end
    if (res_valid && sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (res_data !== e.data || res_error !== e.err) begin
        failures++;
        $display("FAIL done_result got=%0d/%b exp=%0d/%b",
                 res_data, res_error, e.data, e.err);
      end
    end
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL done_return got valid=%b ready=%b busy=%b exp=0,1,0",
               res_valid, in_ready, busy);
    end
  endtask

  task automatic test_timeout_hold;
    int   n;
    exp_t e;
    res_ready = 1'b0;
    stream(5'd1, 5'd2, 5'd3, 5'd4);
    sb.push_back('{data: 5'd0, err: 1'b1});
    @(negedge clk);
    n = 0;
    while (!res_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== TO) begin
      failures++;
      $display("FAIL timeout_wait_cycles got=%0d exp=%0d", n, TO);
    end
    e = '0;
    if (sb.size() > 0) e = sb.pop_front();
    checks++;
    if (res_valid !== 1'b1 || res_data !== e.data || res_error !== e.err) begin
      failures++;
      $display("FAIL timeout_result got=%b/%0d/%b exp=1/%0d/%b",
               res_valid, res_data, res_error, e.data, e.err);
    end
    for (int i = 0; i < 10; i++) begin
      in_valid       = i[0];
      in_data        = 5'd31;
      done           = 1'b1;
      maximum_number = 5'd21;
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || res_data !== e.data ||
          res_error !== e.err || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_cycle%0d got valid=%b data=%0d err=%b ready=%b exp=1/%0d/%b/0",
                 i, res_valid, res_data, res_error, in_ready, e.data, e.err);
      end
    end
    in_valid  = 1'b0;
    done      = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL hold_release got valid=%b ready=%b busy=%b exp=0,1,0",
               res_valid, in_ready, busy);
    end
    checks++;
    if ({X1, X2, X3, X4} !== {5'd1, 5'd2, 5'd3, 5'd4}) begin
      failures++;
      $display("FAIL hold_x got=%0d,%0d,%0d,%0d exp=1,2,3,4", X1, X2, X3, X4);
    end
  endtask

  // done arrives in the same cycle the watchdog reaches TIMEOUT-1.
  task automatic test_coincide;
    exp_t e;
    res_ready = 1'b1;
    stream(5'd12, 5'd25, 5'd7, 5'd19);
    repeat (TO) @(negedge clk);
    checks++;
    if (res_valid !== 1'b0) begin
      failures++;
      $display("FAIL coincide_early got valid=%b exp=0", res_valid);
    end
    done           = 1'b1;
    maximum_number = max4(5'd12, 5'd25, 5'd7, 5'd19);
    sb.push_back('{data: maximum_number, err: 1'b0});
    @(negedge clk);
    done = 1'b0;
    e = '0;
    if (sb.size() > 0) e = sb.pop_front();
    checks++;
    if (res_valid !== 1'b1 || res_data !== e.data || res_error !== e.err) begin
      failures++;
      $display("FAIL coincide_result got=%b/%0d/%b exp=1/%0d/%b",
               res_valid, res_data, res_error, e.data, e.err);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    exp_t e;
    in_valid = 1'b1;
    in_data  = 5'd1;
    @(negedge clk);
    in_data  = 5'd2;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || X1 !== 5'd1 || X2 !== 5'd2) begin
      failures++;
      $display("FAIL partial_load got busy=%b x1=%0d x2=%0d exp=1,1,2", busy, X1, X2);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({X1, X2, X3, X4} !== 20'd0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL async_reset_collect got x=%h busy=%b ready=%b exp=0,0,1",
               {X1, X2, X3, X4}, busy, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    stream(5'd5, 5'd6, 5'd7, 5'd8);
    checks++;
    if ({X1, X2, X3, X4} !== {5'd5, 5'd6, 5'd7, 5'd8} || start_signal !== 1'b1) begin
      failures++;
      $display("FAIL after_reset_x got=%0d,%0d,%0d,%0d start=%b exp=5,6,7,8 1",
               X1, X2, X3, X4, start_signal);
    end
    res_ready = 1'b0;
    repeat (2) @(negedge clk);
    done           = 1'b1;
    maximum_number = max4(5'd5, 5'd6, 5'd7, 5'd8);
    sb.push_back('{data: maximum_number, err: 1'b0});
    @(negedge clk);
    done = 1'b0;
    e = '0;
    if (sb.size() > 0) e = sb.pop_front();
    checks++;
    if (res_valid !== 1'b1 || res_data !== e.data || res_error !== e.err) begin
      failures++;
      $display("FAIL after_reset_result got=%b/%0d/%b exp=1/%0d/%b",
               res_valid, res_data, res_error, e.data, e.err);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (res_valid !== 1'b0 || res_data !== 5'd0 || res_error !== 1'b0 ||
        {X1, X2, X3, X4} !== 20'd0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL async_reset_deliver got valid=%b data=%0d err=%b x=%h ready=%b exp=0,0,0,0,1",
               res_valid, res_data, res_error, {X1, X2, X3, X4}, in_ready);
    end
    @(negedge clk);
    rst       = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || start_signal !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle got valid=%b start=%b busy=%b exp=0,0,0",
               res_valid, start_signal, busy);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_done();
    test_timeout_hold();
    test_coincide();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
